// File: rtl/rom_dl_sched.sv
// Download scheduler: routes ioctl bytes to SDRAM port1/port2 (toggle req/ack) or the BG ROM strobe.
// Optional ack watchdog enabled by defining DL_TIMEOUT_EN.
//
// state   | meaning
// IDLE    | ready for a byte; dl bytes are written straight through from here
// P1_WAIT | port1 request outstanding, host stalled via ioctl_wait
// P2_WAIT | port2 request outstanding, host stalled via ioctl_wait
module rom_dl_sched #(
    parameter logic [24:0] SP_BASE = 25'h12000,
    parameter logic [24:0] BG_BASE = 25'h32000,
    parameter logic [24:0] BG_END  = 25'h3A000
`ifdef DL_TIMEOUT_EN
    ,
    parameter int unsigned TIMEOUT = 255
`endif
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic        ioctl_wr,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    output logic        ioctl_wait,
    output logic        port1_req,
    input  logic        port1_ack,
    output logic [22:0] port1_a,
    output logic [1:0]  port1_ds,
    output logic [15:0] port1_d,
    output logic        port2_req,
    input  logic        port2_ack,
    output logic [17:0] port2_a,
    output logic [1:0]  port2_ds,
    output logic [15:0] port2_d,
    output logic        dl_wr,
    output logic [15:0] dl_addr,
    output logic [7:0]  dl_data,
    output logic        rom_loaded,
    output logic        dl_error
);

    typedef enum logic [1:0] {IDLE, P1_WAIT, P2_WAIT} state_t;

    state_t      state, state_nx;
    logic        wr_s, wr_q, dl_q, load_pend;
    logic        capture, accept, overrun;
    logic        in_p1, in_p2, in_bg;
    logic        dl_rise, dl_fall;
    logic [18:0] sp_off;
    logic [15:0] bg_off;
    logic        tmo_fire;

    // The strobe is registered once so a capture lands the cycle after ioctl_wr rises.
    assign capture = wr_s & ~wr_q & ioctl_download;
    assign accept  = capture && (state == IDLE);
    assign overrun = capture && (state != IDLE);
    assign dl_rise = ioctl_download & ~dl_q;
    assign dl_fall = ~ioctl_download & dl_q;

    assign in_p1  = ioctl_addr < SP_BASE;
    assign in_p2  = (ioctl_addr >= SP_BASE) && (ioctl_addr < BG_BASE);
    assign in_bg  = (ioctl_addr >= BG_BASE) && (ioctl_addr < BG_END);
    assign sp_off = ioctl_addr[18:0] - SP_BASE[18:0];
    assign bg_off = ioctl_addr[15:0] - BG_BASE[15:0];

`ifdef DL_TIMEOUT_EN
    logic [7:0] tmo_cnt;

    // Down-counter reloaded while idle; terminal count is the last permitted wait cycle.
    assign tmo_fire = (state != IDLE) && (tmo_cnt == 8'd1);

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            tmo_cnt <= 8'(TIMEOUT);
        else if (state == IDLE)
            tmo_cnt <= 8'(TIMEOUT);
        else if (tmo_cnt != 8'd0)
            tmo_cnt <= tmo_cnt - 8'd1;
    end
`else
    assign tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE: begin
                if (accept && in_p1)
                    state_nx = P1_WAIT;
                else if (accept && in_p2)
                    state_nx = P2_WAIT;
            end
            P1_WAIT: if ((port1_ack == port1_req) || tmo_fire) state_nx = IDLE;
            P2_WAIT: if ((port2_ack == port2_req) || tmo_fire) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        ioctl_wait = (state == P1_WAIT) || (state == P2_WAIT);
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            wr_s       <= 1'b0;
            wr_q       <= 1'b0;
            dl_q       <= 1'b0;
            load_pend  <= 1'b0;
            port1_req  <= 1'b0;
            port1_a    <= '0;
            port1_ds   <= '0;
            port1_d    <= '0;
            port2_req  <= 1'b0;
            port2_a    <= '0;
            port2_ds   <= '0;
            port2_d    <= '0;
            dl_wr      <= 1'b0;
            dl_addr    <= '0;
            dl_data    <= '0;
            rom_loaded <= 1'b0;
            dl_error   <= 1'b0;
        end else begin
            wr_s  <= ioctl_wr;
            wr_q  <= wr_s;
            dl_q  <= ioctl_download;
            dl_wr <= 1'b0;

            if (accept && in_p1) begin
                port1_req <= ~port1_req;
                port1_a   <= ioctl_addr[23:1];
                port1_ds  <= {ioctl_addr[0], ~ioctl_addr[0]};
                port1_d   <= {ioctl_dout, ioctl_dout};
            end
            if (accept && in_p2) begin
                port2_req <= ~port2_req;
                port2_a   <= {sp_off[18:17], sp_off[14:0], sp_off[16]};
                port2_ds  <= {sp_off[15], ~sp_off[15]};
                port2_d   <= {ioctl_dout, ioctl_dout};
            end
            if (accept && in_bg) begin
                dl_wr   <= 1'b1;
                dl_addr <= bg_off;
                dl_data <= ioctl_dout;
            end

            // A falling download edge seen mid-wait is remembered until the FSM is idle.
            if (dl_rise) begin
                rom_loaded <= 1'b0;
                load_pend  <= 1'b0;
                dl_error   <= 1'b0;
            end else if ((dl_fall || load_pend) && (state == IDLE)) begin
                rom_loaded <= 1'b1;
                load_pend  <= 1'b0;
            end else if (dl_fall) begin
                load_pend <= 1'b1;
            end

            if (overrun || tmo_fire)
                dl_error <= 1'b1;
        end
    end

endmodule

// File: tb/tb_rom_dl_sched.sv
// Scoreboard bench for rom_dl_sched: a monitor pops expected port/BG writes as the DUT produces them,
// scenario tasks check wait lengths, error/loaded flags and reset behaviour inline.
module tb_rom_dl_sched;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download, ioctl_wr;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wait;
    logic        port1_req, port1_ack;
    logic [22:0] port1_a;
    logic [1:0]  port1_ds;
    logic [15:0] port1_d;
    logic        port2_req, port2_ack;
    logic [17:0] port2_a;
    logic [1:0]  port2_ds;
    logic [15:0] port2_d;
    logic        dl_wr;
    logic [15:0] dl_addr;
    logic [7:0]  dl_data;
    logic        rom_loaded, dl_error;

    typedef struct {
        int          kind;
        logic [22:0] a;
        logic [1:0]  ds;
        logic [15:0] d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_p1 = 0, n_p2 = 0, n_dl = 0;

    rom_dl_sched dut (
        .clk_sys(clk_sys), .reset(reset),
        .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr),
        .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
        .port1_req(port1_req), .port1_ack(port1_ack), .port1_a(port1_a),
        .port1_ds(port1_ds), .port1_d(port1_d),
        .port2_req(port2_req), .port2_ack(port2_ack), .port2_a(port2_a),
        .port2_ds(port2_ds), .port2_d(port2_d),
        .dl_wr(dl_wr), .dl_addr(dl_addr), .dl_data(dl_data),
        .rom_loaded(rom_loaded), .dl_error(dl_error)
    );

    always #5 clk_sys = ~clk_sys;

    // SDRAM ack model: echoes req after 'lat' cycles, combinationally when zero_lat, never while held.
    logic ack1_r, ack2_r;
    int   c1, c2;
    bit   hold1 = 0, hold2 = 0, zero_lat = 0;
    int   lat = 1;

    assign port1_ack = zero_lat ? port1_req : ack1_r;
    assign port2_ack = zero_lat ? port2_req : ack2_r;

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack1_r <= 1'b0; c1 <= 0;
        end else if (zero_lat) begin
            ack1_r <= port1_req;
        end else if (!hold1 && port1_req != ack1_r) begin
            if (c1 + 1 >= lat) begin ack1_r <= port1_req; c1 <= 0; end
            else c1 <= c1 + 1;
        end
    end

    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            ack2_r <= 1'b0; c2 <= 0;
        end else if (zero_lat) begin
            ack2_r <= port2_req;
        end else if (!hold2 && port2_req != ack2_r) begin
            if (c2 + 1 >= lat) begin ack2_r <= port2_req; c2 <= 0; end
            else c2 <= c2 + 1;
        end
    end

    function automatic exp_t model(input logic [24:0] addr, input logic [7:0] data);
        exp_t        e;
        logic [24:0] off;
        e = '{0, '0, '0, '0};
        if (addr < 25'h12000) begin
            e.kind = 1; e.a = addr[23:1]; e.ds = {addr[0], ~addr[0]}; e.d = {data, data};
        end else if (addr < 25'h32000) begin
            off = addr - 25'h12000;
            e.kind = 2; e.a = {5'd0, off[18:17], off[14:0], off[16]};
            e.ds = {off[15], ~off[15]}; e.d = {data, data};
        end else if (addr < 25'h3A000) begin
            off = addr - 25'h32000;
            e.kind = 3; e.a = {7'd0, off[15:0]}; e.d = {8'd0, data};
        end
        return e;
    endfunction

    // Output monitor: every req toggle or dl_wr pulse must match the head of the scoreboard.
    exp_t act, exp_e;
    logic p1_prev = 1'b0, p2_prev = 1'b0;
    bit   hit;

    always @(negedge clk_sys) begin
        if (reset) begin
            p1_prev = port1_req;
            p2_prev = port2_req;
        end else begin
            for (int k = 1; k <= 3; k++) begin
                hit = 0;
                act = '{0, '0, '0, '0};
                if (k == 1 && port1_req !== p1_prev) begin
                    hit = 1; p1_prev = port1_req; n_p1++;
                    act = '{1, port1_a, port1_ds, port1_d};
                end
                if (k == 2 && port2_req !== p2_prev) begin
                    hit = 1; p2_prev = port2_req; n_p2++;
                    act = '{2, {5'd0, port2_a}, port2_ds, port2_d};
                end
                if (k == 3 && dl_wr === 1'b1) begin
                    hit = 1; n_dl++;
                    act = '{3, {7'd0, dl_addr}, 2'b00, {8'd0, dl_data}};
                end
                if (hit) begin
                    checks++;
                    if (sb.size() == 0) begin
                        errors++;
                        $display("FAIL out_unexpected got kind=%0d a=%h ds=%b d=%h, required no output",
                                 act.kind, act.a, act.ds, act.d);
                    end else begin
                        exp_e = sb.pop_front();
                        if (act.kind !== exp_e.kind || act.a !== exp_e.a ||
                            act.ds !== exp_e.ds || act.d !== exp_e.d) begin
                            errors++;
                            $display("FAIL out_match got kind=%0d a=%h ds=%b d=%h required kind=%0d a=%h ds=%b d=%h",
                                     act.kind, act.a, act.ds, act.d, exp_e.kind, exp_e.a, exp_e.ds, exp_e.d);
                        end
                    end
                end
            end
        end
    end

    task automatic send_byte(input logic [24:0] addr, input logic [7:0] data, input bit push);
        exp_t e;
        @(posedge clk_sys); #1;
        ioctl_addr = addr;
        ioctl_dout = data;
        ioctl_wr   = 1'b1;
        e = model(addr, data);
        if (push && e.kind != 0) sb.push_back(e);
        @(posedge clk_sys); #1;
        ioctl_wr = 1'b0;
    endtask

    task automatic measure_wait(input int limit, output int n);
        n = 0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk_sys);
            if (ioctl_wait) n++;
            else if (n > 0) break;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk_sys);
        checks++;
        if ({ioctl_wait, port1_req, port2_req, dl_wr, rom_loaded, dl_error} !== 6'b0) begin
            errors++;
            $display("FAIL reset_outputs got %b required 000000",
                     {ioctl_wait, port1_req, port2_req, dl_wr, rom_loaded, dl_error});
        end
        @(posedge clk_sys); #1;
        reset = 1'b0;
        ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (rom_loaded !== 1'b0 || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL post_reset got loaded=%b wait=%b required 0 0", rom_loaded, ioctl_wait);
        end
    endtask

    task automatic test_port1();
        int          n, b, exp_n;
        logic [24:0] addrs [4];
        int          lats  [4];
        lat = 3; b = n_p1;
        send_byte(25'h00003, 8'h5A, 1);
        measure_wait(20, n);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL p1_wait_len got %0d required 4", n); end
        checks++;
        if (n_p1 - b !== 1) begin errors++; $display("FAIL p1_toggles got %0d required 1", n_p1 - b); end
        checks++;
        if (port1_a !== 23'h000001 || port1_ds !== 2'b10 || port1_d !== 16'h5A5A) begin
            errors++;
            $display("FAIL p1_fields got a=%h ds=%b d=%h required 000001 10 5a5a", port1_a, port1_ds, port1_d);
        end
        addrs = '{25'h00000, 25'h11FFF, 25'(($urandom_range(32'h11FFF, 0)) & 32'h1FFFE), 25'h00777};
        lats  = '{1, 5, 2, 0};
        for (int i = 0; i < 4; i++) begin
            zero_lat = (lats[i] == 0);
            lat = (lats[i] == 0) ? 1 : lats[i];
            exp_n = lats[i] + 1;
            send_byte(addrs[i], 8'($urandom_range(255, 0)), 1);
            measure_wait(20, n);
            checks++;
            if (n !== exp_n) begin
                errors++;
                $display("FAIL p1_wait_lat%0d got %0d required %0d", lats[i], n, exp_n);
            end
            zero_lat = 0;
            repeat (2) @(posedge clk_sys);
        end
    endtask

    task automatic test_port2();
        int n, b1, b2;
        lat = 2; b1 = n_p1; b2 = n_p2;
        send_byte(25'h2A001, 8'hC3, 1);
        measure_wait(20, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL p2_wait_len got %0d required 3", n); end
        checks++;
        if (n_p1 !== b1 || n_p2 - b2 !== 1) begin
            errors++;
            $display("FAIL p2_toggles got p1=%0d p2=%0d required 0 1", n_p1 - b1, n_p2 - b2);
        end
        checks++;
        if (port2_a !== 18'h00003 || port2_ds !== 2'b10 || port2_d !== 16'hC3C3) begin
            errors++;
            $display("FAIL p2_fields got a=%h ds=%b d=%h required 00003 10 c3c3", port2_a, port2_ds, port2_d);
        end
        lat = 1;
        send_byte(25'h12000, 8'h01, 1);
        measure_wait(20, n);
        send_byte(25'h31FFF, 8'hFE, 1);
        measure_wait(20, n);
        checks++;
        if (n !== 2) begin errors++; $display("FAIL p2_wait_lat1 got %0d required 2", n); end
    endtask

    task automatic test_dl();
        int n, b, bp;
        b = n_dl; bp = n_p1 + n_p2;
        send_byte(25'h32010, 8'h77, 1);
        measure_wait(8, n);
        checks++;
        if (n !== 0 || dl_addr !== 16'h0010 || dl_data !== 8'h77) begin
            errors++;
            $display("FAIL dl_basic got wait=%0d addr=%h data=%h required 0 0010 77", n, dl_addr, dl_data);
        end
        send_byte(25'h39FFF, 8'h42, 1);
        measure_wait(8, n);
        send_byte(25'h3A000, 8'h13, 1);
        measure_wait(8, n);
        send_byte(25'h1FFFFFF, 8'h24, 1);
        measure_wait(8, n);
        checks++;
        if (n !== 0 || n_dl - b !== 2 || n_p1 + n_p2 !== bp) begin
            errors++;
            $display("FAIL dl_drop got wait=%0d dl=%0d ports=%0d required 0 2 0", n, n_dl - b, n_p1 + n_p2 - bp);
        end
    endtask

    task automatic test_back_to_back();
        int b, wait_seen;
        b = n_dl; wait_seen = 0;
        for (int i = 0; i < 6; i++) begin
            send_byte(25'(32'h32000 + i * 257), 8'(i * 17 + 3), 1);
            if (ioctl_wait) wait_seen++;
        end
        repeat (4) @(negedge clk_sys);
        checks++;
        if (n_dl - b !== 6 || wait_seen !== 0 || sb.size() !== 0) begin
            errors++;
            $display("FAIL b2b got writes=%0d wait=%0d pending=%0d required 6 0 0", n_dl - b, wait_seen, sb.size());
        end
    endtask

    task automatic test_overrun();
        int n, b;
        lat = 2; hold1 = 1; b = n_p1;
        send_byte(25'h00100, 8'hA1, 1);
        repeat (2) @(negedge clk_sys);
        send_byte(25'h00102, 8'hB2, 0);
        repeat (2) @(negedge clk_sys);
        checks++;
        if (ioctl_wait !== 1'b1 || dl_error !== 1'b1) begin
            errors++;
            $display("FAIL overrun_flag got wait=%b err=%b required 1 1", ioctl_wait, dl_error);
        end
        hold1 = 0;
        measure_wait(20, n);
        checks++;
        if (n_p1 - b !== 1 || port1_a !== 23'h000080 || port1_d !== 16'hA1A1) begin
            errors++;
            $display("FAIL overrun_discard got toggles=%0d a=%h d=%h required 1 000080 a1a1", n_p1 - b, port1_a, port1_d);
        end
        @(posedge clk_sys); #1 ioctl_download = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1 ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (dl_error !== 1'b0) begin errors++; $display("FAIL err_clear got %b required 0", dl_error); end
    endtask

    task automatic test_rom_loaded();
        int bad;
        lat = 1; hold2 = 1; bad = 0;
        send_byte(25'h20000, 8'h3C, 1);
        @(posedge clk_sys); #1 ioctl_download = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk_sys);
            if (rom_loaded) bad++;
        end
        checks++;
        if (bad !== 0 || ioctl_wait !== 1'b1) begin
            errors++;
            $display("FAIL loaded_deferred got early=%0d wait=%b required 0 1", bad, ioctl_wait);
        end
        hold2 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_sys);
            if (!ioctl_wait) break;
        end
        checks++;
        if (ioctl_wait !== 1'b0 || rom_loaded !== 1'b0) begin
            errors++;
            $display("FAIL loaded_idle_cycle got wait=%b loaded=%b required 0 0", ioctl_wait, rom_loaded);
        end
        @(negedge clk_sys);
        checks++;
        if (rom_loaded !== 1'b1) begin errors++; $display("FAIL loaded_set got %b required 1", rom_loaded); end
        @(posedge clk_sys); #1 ioctl_download = 1'b1;
        repeat (2) @(negedge clk_sys);
        checks++;
        if (rom_loaded !== 1'b0) begin errors++; $display("FAIL loaded_clear got %b required 0", rom_loaded); end
    endtask

    task automatic test_reset_mid();
        hold1 = 1;
        send_byte(25'h00404, 8'h99, 1);
        repeat (2) @(negedge clk_sys);
        checks++;
        if (ioctl_wait !== 1'b1) begin errors++; $display("FAIL mid_wait got %b required 1", ioctl_wait); end
        @(posedge clk_sys); #1 reset = 1'b1;
        @(negedge clk_sys);
        checks++;
        if ({ioctl_wait, port1_req, port1_a, port1_ds, port1_d, port2_req, port2_a, port2_ds, port2_d,
             dl_wr, dl_addr, dl_data, rom_loaded, dl_error} !== 107'd0) begin
            errors++;
            $display("FAIL reset_mid got wait=%b r1=%b a1=%h r2=%b a2=%h loaded=%b err=%b required all 0",
                     ioctl_wait, port1_req, port1_a, port2_req, port2_a, rom_loaded, dl_error);
        end
        @(posedge clk_sys); #1 reset = 1'b0;
        hold1 = 0;
        repeat (2) @(posedge clk_sys);
    endtask

    task automatic test_timeout();
        int n;
        hold1 = 1;
        send_byte(25'h00600, 8'h11, 1);
        measure_wait(1100, n);
`ifdef DL_TIMEOUT_EN
        checks++;
        if (n !== 255 || dl_error !== 1'b1 || ioctl_wait !== 1'b0) begin
            errors++;
            $display("FAIL timeout got wait_cycles=%0d err=%b wait=%b required 255 1 0", n, dl_error, ioctl_wait);
        end
`else
        checks++;
        if (n <= 1000 || ioctl_wait !== 1'b1 || dl_error !== 1'b0) begin
            errors++;
            $display("FAIL no_timeout got wait_cycles=%0d wait=%b err=%b required >1000 1 0", n, ioctl_wait, dl_error);
        end
`endif
        @(posedge clk_sys); #1 reset = 1'b1;
        @(posedge clk_sys); #1 reset = 1'b0;
        hold1 = 0;
        repeat (2) @(posedge clk_sys);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr = 1'b0;
        ioctl_addr = '0;
        ioctl_dout = '0;
        test_reset();
        test_port1();
        test_port2();
        test_dl();
        test_back_to_back();
        test_overrun();
        test_rom_loaded();
        test_reset_mid();
        test_timeout();
        checks++;
        if (sb.size() !== 0) begin errors++; $display("FAIL sb_drained got %0d pending required 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
